fetch_unit: RTL and testbench

//  Instruction-fetch stage. Owns the PC, issues req/ack reads to instruction

---
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, keeps one req/ack read outstanding to instruction memory and
// queues returned words with their PCs. Optional macro FETCH_HALT_EN stops fetch after a HALT word.
module fetch_unit #(
  parameter int AW    = 9,
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          stall,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic          inst_valid,
  output logic [DW-1:0] inst,
  output logic [AW-1:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    req_pc_q, req_pc_d;
  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             halted_q, halted_d;
  logic [AW+DW-1:0] fifo_q [DEPTH];

  logic          ack_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] occ_next_s;
  logic          credit_s;
  logic          halt_word_s;

  // An ack only counts while a request is actually on the bus.
  assign ack_s      = imem_ack && (state_q != IDLE);
  assign push_s     = ack_s && (state_q == WAIT) && !redirect;
  assign pop_s      = (count_q != '0) && !stall;
  assign occ_next_s = count_q - CW'(pop_s) + CW'(push_s);
  assign credit_s   = (occ_next_s < DEPTH_C);

`ifdef FETCH_HALT_EN
  assign halt_word_s = push_s && (imem_rdata[DW-1:DW-3] == 3'b111);
`else
  assign halt_word_s = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    fetch_pc_d = fetch_pc_q;
    halted_d   = halted_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      // A request already on the bus cannot be withdrawn; its data is dropped instead.
      case (state_q)
        IDLE: begin
          state_d  = WAIT;
          req_pc_d = redirect_pc;
        end
        WAIT: begin
          if (ack_s) begin
            state_d  = WAIT;
            req_pc_d = redirect_pc;
          end else begin
            state_d = DROP;
          end
        end
        DROP: begin
          state_d = DROP;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          if (credit_s && !halted_q) begin
            state_d  = WAIT;
            req_pc_d = fetch_pc_q;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (ack_s) begin
            fetch_pc_d = req_pc_q + PC_ONE;
            halted_d   = halt_word_s;
            if (credit_s && !halt_word_s) begin
              state_d  = WAIT;
              req_pc_d = req_pc_q + PC_ONE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = WAIT;
          end
        end
        DROP: begin
          if (ack_s) begin
            state_d  = WAIT;
            req_pc_d = fetch_pc_q;
          end else begin
            state_d = DROP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push_s);
      rd_ptr_d = rd_ptr_q + PW'(pop_s);
      count_d  = occ_next_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_pc_q   <= '0;
      fetch_pc_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_pc_q   <= req_pc_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end

  // Queue storage needs no reset: the head is masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      fifo_q[wr_ptr_q] <= {req_pc_q, imem_rdata};
    end
  end

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = req_pc_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? fifo_q[rd_ptr_q][DW-1:0]     : '0;
  assign inst_pc    = inst_valid ? fifo_q[rd_ptr_q][AW+DW-1:DW] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random req/ack/stall/redirect
// traffic, all checked against a transaction-level queue model of the fetch stream.
module tb_fetch_unit;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  // Instruction memory contents; address 2 holds a HALT word.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 9'd2) return 16'hE000;
    return {3'b010, a[3:0] ^ 4'h9, a};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected queue contents, next useful fetch PC, wrong-path request flag.
  logic [AW+DW-1:0] q[$];
  logic [AW-1:0]    m_next_pc;
  bit               m_drop, m_halted, m_exp_req, m_ok;
  bit               p_req, p_ack, p_reset;
  logic [AW-1:0]    p_addr;
  bit               ack_rand, ack_want;
  int               ack_pct;

  task automatic tick();
    int            sz;
    bit            pop, hw;
    logic [DW-1:0] w;
    @(negedge clk);
    if (m_ok) begin
      check_eq("inst_valid", 32'(inst_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check_eq("inst", 32'(inst), 32'(q[0][DW-1:0]));
        check_eq("inst_pc", 32'(inst_pc), 32'(q[0][AW+DW-1:DW]));
      end else begin
        check_eq("inst_empty", 32'(inst), 32'd0);
        check_eq("inst_pc_empty", 32'(inst_pc), 32'd0);
      end
      check_eq("imem_req", 32'(imem_req), 32'(m_exp_req));
      if (!p_reset) check_eq("rst_addr", 32'(imem_addr), 32'd0);
      else if (p_req && !p_ack) check_eq("addr_hold", 32'(imem_addr), 32'(p_addr));
      if (imem_req && !m_drop) check_eq("imem_addr", 32'(imem_addr), 32'(m_next_pc));
    end
    imem_ack = imem_req && (ack_rand ? ($urandom_range(0, 99) < ack_pct) : ack_want);
    sz  = q.size();
    pop = (sz != 0) && !stall;
    if (!reset) begin
      q.delete();
      m_next_pc = '0;
      m_drop    = 1'b0;
      m_halted  = 1'b0;
      m_exp_req = 1'b0;
      m_ok      = 1'b1;
    end else if (m_ok) begin
      if (redirect) begin
        q.delete();
        m_next_pc = redirect_pc;
        m_halted  = 1'b0;
        m_drop    = imem_req && (m_drop || !imem_ack);
        m_exp_req = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (imem_req && imem_ack) begin
          if (m_drop) begin
            m_drop    = 1'b0;
            m_exp_req = 1'b1;
          end else begin
            w  = mem_word(m_next_pc);
            q.push_back({m_next_pc, w});
            hw = HALT_EN && (w[15:13] == 3'b111);
            m_exp_req = (q.size() < DEPTH) && !hw;
            if (hw) m_halted = 1'b1;
            m_next_pc = m_next_pc + 9'd1;
          end
        end else if (imem_req) begin
          m_exp_req = 1'b1;
        end else begin
          m_exp_req = !m_halted && (q.size() < DEPTH);
        end
      end
    end
    p_req   = imem_req;
    p_ack   = imem_ack;
    p_reset = reset;
    p_addr  = imem_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; imem_ack = 1'b0;
    ack_rand = 1'b0; ack_want = 1'b0; ack_pct = 60; m_ok = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_reset = 1'b0; p_addr = '0;

    // Reset held two cycles
    tick(); tick();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr0", 32'(imem_addr), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_inst", 32'(inst), 32'd0);
    check_eq("rst_inst_pc", 32'(inst_pc), 32'd0);

    // Zero-wait streaming
    reset = 1'b1; ack_want = 1'b1;
    repeat (12) tick();
    check_eq("t1_valid", 32'(inst_valid), 32'd1);
    check_eq("t1_lag", 32'(imem_addr - inst_pc), 32'd1);

    // Stall from the start: queue fills, then drains in order
    reset = 1'b0; tick(); reset = 1'b1; stall = 1'b1;
    repeat (10) tick();
    check_eq("t2_req_low", 32'(imem_req), 32'd0);
    check_eq("t2_head", 32'(inst_pc), 32'd0);
    stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("t2_pop_order", 32'(inst_pc), 32'(k));
      if (k == 1) check_eq("t2_resume_addr", 32'(imem_addr), 32'd4);
    end

    // Redirect while waiting on a slow ack
    reset = 1'b0; tick(); reset = 1'b1; ack_want = 1'b0;
    for (int k = 0; k < 5 && !imem_req; k++) tick();
    redirect = 1'b1; redirect_pc = 9'h1F0;
    tick();
    redirect = 1'b0;
    tick(); tick();
    ack_want = 1'b1;
    for (int k = 0; k < 10 && !inst_valid; k++) tick();
    check_eq("t3_valid", 32'(inst_valid), 32'd1);
    check_eq("t3_first_pc", 32'(inst_pc), 32'h1F0);

    // Redirect coinciding with an ack
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 9'h040;
    tick();
    redirect = 1'b0;
    check_eq("t4_addr", 32'(imem_addr), 32'h040);
    check_eq("t4_flush", 32'(inst_valid), 32'd0);
    tick();
    check_eq("t4_first_pc", 32'(inst_pc), 32'h040);

    // Address wrap, then reset in the middle of a wait
    redirect = 1'b1; redirect_pc = 9'h1FE;
    tick();
    redirect = 1'b0;
    check_eq("t5_addr0", 32'(imem_addr), 32'h1FE);
    tick();
    check_eq("t5_addr1", 32'(imem_addr), 32'h1FF);
    tick();
    check_eq("t5_wrap", 32'(imem_addr), 32'h000);
    ack_want = 1'b0;
    tick(); tick();
    reset = 1'b0; ack_want = 1'b1;
    tick();
    check_eq("t5_rst_req", 32'(imem_req), 32'd0);
    check_eq("t5_rst_addr", 32'(imem_addr), 32'd0);
    check_eq("t5_rst_valid", 32'(inst_valid), 32'd0);
    check_eq("t5_rst_inst", 32'(inst), 32'd0);
    check_eq("t5_rst_pc", 32'(inst_pc), 32'd0);
    reset = 1'b1;
    tick(); tick();

    // HALT word at address 2
    reset = 1'b0; tick(); reset = 1'b1;
    repeat (10) tick();
`ifdef FETCH_HALT_EN
    check_eq("t6_halted_req", 32'(imem_req), 32'd0);
    redirect = 1'b1; redirect_pc = 9'd5;
    tick();
    redirect = 1'b0;
    check_eq("t6_resume_addr", 32'(imem_addr), 32'd5);
`else
    check_eq("t6_no_halt_req", 32'(imem_req), 32'd1);
`endif

    // Random traffic
    ack_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ack_pct     = (i < 1000) ? 100 : ((i < 2000) ? 60 : 25);
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 3);
      redirect_pc = AW'($urandom);
      reset       = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1; redirect = 1'b0; stall = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
